// File: rtl/cordic_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cordic_channel_scheduler
// Purpose  : Shares one iterative CORDIC rotator (rotation mode, circular)
//            between N_CH waveform channels. Round-robin arbitration picks a
//            requesting channel, latches its amplitude (X seed) and phase (Z),
//            fires a one-cycle start strobe, waits for the core's done pulse
//            and returns cos/sin tagged with the channel index.
// Ports    : clk_i, rstn_i (async, active-low)
//            req_i/amp_i/phase_i   per-channel request + packed operands
//            gnt_o                 one-hot grant pulse (operands captured)
//            busy_o                high whenever the FSM is not IDLE
//            cordic_strb_o/x_o/z_o start strobe and operands to the core
//            cordic_done_i/x_i/y_i done pulse and cos/sin from the core
//            res_valid_o/ch_o/cos_o/sin_o  tagged result, valid for 1 cycle
//            timeout_o             WAIT timeout pulse
// Config   : CORDIC_SCHED_TIMEOUT_EN - when defined, WAIT gives up after
//            TIMEOUT_CYCLES cycles without done; otherwise timeout_o is 0.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_channel_scheduler #(
    parameter  int N_CH           = 2,
    parameter  int BITWIDTH       = 10,
    parameter  int TIMEOUT_CYCLES = 15,
    localparam int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [N_CH-1:0]          req_i,
    input  logic [N_CH*BITWIDTH-1:0] amp_i,
    input  logic [N_CH*BITWIDTH-1:0] phase_i,
    output logic [N_CH-1:0]          gnt_o,
    output logic                     busy_o,
    output logic                     cordic_strb_o,
    output logic [BITWIDTH-1:0]      cordic_x_o,
    output logic [BITWIDTH-1:0]      cordic_z_o,
    input  logic                     cordic_done_i,
    input  logic [BITWIDTH-1:0]      cordic_x_i,
    input  logic [BITWIDTH-1:0]      cordic_y_i,
    output logic                     res_valid_o,
    output logic [CH_W-1:0]          res_ch_o,
    output logic [BITWIDTH-1:0]      res_cos_o,
    output logic [BITWIDTH-1:0]      res_sin_o,
    output logic                     timeout_o
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // Elaboration-time sanity checks on the configuration.
    if (N_CH < 2) begin : g_bad_n_ch
        $error("cordic_channel_scheduler: N_CH must be >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cordic_channel_scheduler: TIMEOUT_CYCLES must be >= 1");
    end

    logic [1:0]          r_state;
    logic [CH_W-1:0]     r_ptr;
    logic [CH_W-1:0]     r_win;
    logic [N_CH-1:0]     r_gnt;
    logic                r_strb;
    logic [BITWIDTH-1:0] r_x;
    logic [BITWIDTH-1:0] r_z;
    logic                r_res_valid;
    logic [CH_W-1:0]     r_res_ch;
    logic [BITWIDTH-1:0] r_cos;
    logic [BITWIDTH-1:0] r_sin;

    // Round-robin search: walk from the pointer upward, wrapping at N_CH-1.
    // The sum carries one extra bit so the wrap works for any N_CH.
    logic            w_found;
    logic [CH_W-1:0] w_winner;
    logic [CH_W:0]   w_sum;
    logic [CH_W-1:0] w_ptr_next;
    logic [N_CH-1:0] w_gnt_onehot;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_sum = {1'b0, r_ptr} + (CH_W+1)'(i);
            if (w_sum >= (CH_W+1)'(N_CH)) begin
                w_sum = w_sum - (CH_W+1)'(N_CH);
            end
            if (!w_found && req_i[w_sum[CH_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[CH_W-1:0];
            end
        end
    end

    assign w_ptr_next   = (w_winner == CH_W'(N_CH-1)) ? '0 : w_winner + 1'b1;
    assign w_gnt_onehot = N_CH'(1) << w_winner;

`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [c_TO_W-1:0] r_cnt;
    logic              r_timeout;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= c_ST_IDLE;
            r_ptr       <= '0;
            r_win       <= '0;
            r_gnt       <= '0;
            r_strb      <= 1'b0;
            r_x         <= '0;
            r_z         <= '0;
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_cos       <= '0;
            r_sin       <= '0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; each state raises only what it owns.
            r_gnt       <= '0;
            r_strb      <= 1'b0;
            r_res_valid <= 1'b0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
            case (r_state)
                c_ST_IDLE: begin
                    if (w_found) begin
                        r_state <= c_ST_START;
                        r_win   <= w_winner;
                        r_ptr   <= w_ptr_next;
                        r_gnt   <= w_gnt_onehot;
                        r_strb  <= 1'b1;
                        r_x     <= amp_i[w_winner*BITWIDTH +: BITWIDTH];
                        r_z     <= phase_i[w_winner*BITWIDTH +: BITWIDTH];
                    end
                end
                c_ST_START: begin
                    // A done arriving on the strobe cycle is stale; ignore it.
                    r_state <= c_ST_WAIT;
`ifdef CORDIC_SCHED_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                c_ST_WAIT: begin
                    if (cordic_done_i) begin
                        r_state     <= c_ST_DONE;
                        r_res_valid <= 1'b1;
                        r_res_ch    <= r_win;
                        r_cos       <= cordic_x_i;
                        r_sin       <= cordic_y_i;
                    end
`ifdef CORDIC_SCHED_TIMEOUT_EN
                    // Done has priority over a coincident limit.
                    else if (r_cnt == c_TO_W'(TIMEOUT_CYCLES-1)) begin
                        r_state   <= c_ST_IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o         = r_gnt;
    assign busy_o        = (r_state != c_ST_IDLE);
    assign cordic_strb_o = r_strb;
    assign cordic_x_o    = r_x;
    assign cordic_z_o    = r_z;
    assign res_valid_o   = r_res_valid;
    assign res_ch_o      = r_res_ch;
    assign res_cos_o     = r_cos;
    assign res_sin_o     = r_sin;
`ifdef CORDIC_SCHED_TIMEOUT_EN
    assign timeout_o     = r_timeout;
`else
    assign timeout_o     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cordic_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_channel_scheduler
// Purpose  : Directed self-checking bench for cordic_channel_scheduler with a
//            CORDIC stub (done 11 cycles after strobe, returns X=amp, Y=phase).
//            Exercises the timeout path when CORDIC_SCHED_TIMEOUT_EN is set,
//            otherwise the wait-forever path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_channel_scheduler;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [1:0]  req_i;
    logic [19:0] amp_i;
    logic [19:0] phase_i;
    logic [1:0]  gnt_o;
    logic        busy_o;
    logic        cordic_strb_o;
    logic [9:0]  cordic_x_o;
    logic [9:0]  cordic_z_o;
    logic        cordic_done_i;
    logic [9:0]  cordic_x_i;
    logic [9:0]  cordic_y_i;
    logic        res_valid_o;
    logic [0:0]  res_ch_o;
    logic [9:0]  res_cos_o;
    logic [9:0]  res_sin_o;
    logic        timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    cordic_channel_scheduler #(
        .N_CH(2), .BITWIDTH(10), .TIMEOUT_CYCLES(15)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .amp_i(amp_i),
        .phase_i(phase_i), .gnt_o(gnt_o), .busy_o(busy_o),
        .cordic_strb_o(cordic_strb_o), .cordic_x_o(cordic_x_o),
        .cordic_z_o(cordic_z_o), .cordic_done_i(cordic_done_i),
        .cordic_x_i(cordic_x_i), .cordic_y_i(cordic_y_i),
        .res_valid_o(res_valid_o), .res_ch_o(res_ch_o),
        .res_cos_o(res_cos_o), .res_sin_o(res_sin_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // CORDIC stub. mode 0: done 11 cycles after strobe; 1: never done;
    // 2: done only on the strobe cycle itself.
    int         stub_mode = 0;
    int         stub_cnt  = 0;
    logic [9:0] stub_x, stub_y;
    initial begin
        cordic_done_i = 1'b0;
        cordic_x_i    = '0;
        cordic_y_i    = '0;
    end
    always @(negedge clk_i) begin
        cordic_done_i = 1'b0;
        if (cordic_strb_o) begin
            stub_x = cordic_x_o;
            stub_y = cordic_z_o;
            if (stub_mode == 2) begin
                cordic_done_i = 1'b1;
                cordic_x_i    = stub_x;
                cordic_y_i    = stub_y;
                stub_cnt      = 0;
            end else if (stub_mode == 0) begin
                stub_cnt = 11;
            end else begin
                stub_cnt = 0;
            end
        end else if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                cordic_done_i = 1'b1;
                cordic_x_i    = stub_x;
                cordic_y_i    = stub_y;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_res(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!res_valid_o && n < max);
    endtask

    task automatic wait_gnt(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt_o == 2'b00 && n < max);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(gnt_o), 32'h0);
        check({tag, "_busy"},  32'(busy_o), 32'h0);
        check({tag, "_strb"},  32'(cordic_strb_o), 32'h0);
        check({tag, "_x"},     32'(cordic_x_o), 32'h0);
        check({tag, "_z"},     32'(cordic_z_o), 32'h0);
        check({tag, "_valid"}, 32'(res_valid_o), 32'h0);
        check({tag, "_cos"},   32'(res_cos_o), 32'h0);
        check({tag, "_to"},    32'(timeout_o), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        bit seen_b;
        bit seen_c;
        logic [9:0] exp_amp [2];
        logic [9:0] exp_ph  [2];
        exp_amp[0] = 10'h0FF; exp_ph[0] = 10'h080;
        exp_amp[1] = 10'h155; exp_ph[1] = 10'h2AA;

        rstn_i  = 1'b0;
        req_i   = 2'b00;
        amp_i   = {exp_amp[1], exp_amp[0]};
        phase_i = {exp_ph[1], exp_ph[0]};
        tick(); tick();
        check_all_zero("reset");
        check("reset_ch", 32'(res_ch_o), 32'h0);
        rstn_i = 1'b1;
        tick();

        // 1: single request on channel 0
        req_i = 2'b01;
        tick();
        check("t1_gnt",  32'(gnt_o), 32'h1);
        check("t1_strb", 32'(cordic_strb_o), 32'h1);
        check("t1_busy", 32'(busy_o), 32'h1);
        check("t1_x",    32'(cordic_x_o), 32'h0FF);
        check("t1_z",    32'(cordic_z_o), 32'h080);
        req_i = 2'b00;
        wait_res(30, n);
        check("t1_latency", 32'(n), 32'd12);
        check("t1_ch",  32'(res_ch_o), 32'h0);
        check("t1_cos", 32'(res_cos_o), 32'h0FF);
        check("t1_sin", 32'(res_sin_o), 32'h080);
        tick();
        check("t1_idle_busy",  32'(busy_o), 32'h0);
        check("t1_valid_pulse", 32'(res_valid_o), 32'h0);
        check("t1_hold_cos",   32'(res_cos_o), 32'h0FF);

        // 2: both channels requesting continuously, from reset pointer
        rstn_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        req_i  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(30, n);
            check("t2_gnt", 32'(gnt_o), (i % 2 == 0) ? 32'h1 : 32'h2);
            wait_res(30, n);
            check("t2_lat", 32'(n), 32'd12);
            check("t2_ch",  32'(res_ch_o), 32'(i % 2));
            check("t2_cos", 32'(res_cos_o), 32'(exp_amp[i % 2]));
            check("t2_sin", 32'(res_sin_o), 32'(exp_ph[i % 2]));
        end
        req_i = 2'b00;
        tick();
        check("t2_idle", 32'(busy_o), 32'h0);

        // 3: channel 1 raises its request while channel 0 is converting
        req_i = 2'b01;
        tick();
        check("t3_gnt0", 32'(gnt_o), 32'h1);
        req_i = 2'b00;
        tick();
        req_i = 2'b10;
        seen = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (gnt_o != 2'b00) seen = 1'b1;
        end while (!res_valid_o && n < 30);
        check("t3_no_gnt_busy", 32'(seen), 32'h0);
        check("t3_ch0", 32'(res_ch_o), 32'h0);
        tick();
        check("t3_idle_gnt",  32'(gnt_o), 32'h0);
        check("t3_idle_busy", 32'(busy_o), 32'h0);
        tick();
        check("t3_gnt1", 32'(gnt_o), 32'h2);
        req_i = 2'b00;
        wait_res(30, n);
        check("t3_ch1", 32'(res_ch_o), 32'h1);
        check("t3_cos1", 32'(res_cos_o), 32'h155);
        tick();

        // 4: asynchronous reset in the middle of WAIT
        req_i = 2'b01;
        tick();
        req_i = 2'b00;
        tick(); tick(); tick(); tick();
        check("t4_busy_pre", 32'(busy_o), 32'h1);
        rstn_i = 1'b0;
        #1;
        check_all_zero("t4_rst");
        tick(); tick(); tick();
        check("t4_rst_busy", 32'(busy_o), 32'h0);
        rstn_i = 1'b1;
        seen = 1'b0;
        seen_b = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (res_valid_o) seen = 1'b1;
            if (busy_o) seen_b = 1'b1;
        end
        check("t4_no_valid", 32'(seen), 32'h0);
        check("t4_no_busy",  32'(seen_b), 32'h0);

`ifdef CORDIC_SCHED_TIMEOUT_EN
        // 5: stale done on the strobe cycle, then nothing -> timeout
        stub_mode = 2;
        req_i = 2'b01;
        tick();
        check("t5_gnt", 32'(gnt_o), 32'h1);
        req_i = 2'b00;
        seen = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (res_valid_o) seen = 1'b1;
        end while (!timeout_o && n < 40);
        check("t5_to_cycle",  32'(n), 32'd16);
        check("t5_no_valid",  32'(seen), 32'h0);
        check("t5_idle",      32'(busy_o), 32'h0);
        check("t5_cos_kept",  32'(res_cos_o), 32'h0);
        tick();
        check("t5_to_pulse",  32'(timeout_o), 32'h0);
        stub_mode = 0;
        req_i = 2'b10;
        tick();
        check("t5_gnt1", 32'(gnt_o), 32'h2);
        req_i = 2'b00;
        wait_res(30, n);
        check("t5_lat", 32'(n), 32'd12);
        check("t5_ch",  32'(res_ch_o), 32'h1);
        check("t5_sin", 32'(res_sin_o), 32'h2AA);
`else
        // 6: core never answers -> scheduler waits indefinitely
        stub_mode = 1;
        req_i = 2'b01;
        tick();
        check("t6_gnt", 32'(gnt_o), 32'h1);
        req_i = 2'b10;
        seen = 1'b0;
        seen_b = 1'b0;
        seen_c = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (!busy_o) seen = 1'b1;
            if (timeout_o) seen_b = 1'b1;
            if (gnt_o != 2'b00) seen_c = 1'b1;
        end
        check("t6_busy_drop", 32'(seen), 32'h0);
        check("t6_timeout",   32'(seen_b), 32'h0);
        check("t6_gnt_again", 32'(seen_c), 32'h0);
        req_i = 2'b00;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
